// File: rtl/semafor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semafor_pkg
// Description : Shared states, lamp words, mode codes and decode helpers for
//               the demand-driven two-road semafor scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package semafor_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED_BA = 3'd0,
        ST_A_GREEN    = 3'd1,
        ST_A_YELLOW   = 3'd2,
        ST_ALL_RED_AB = 3'd3,
        ST_B_GREEN    = 3'd4,
        ST_B_YELLOW   = 3'd5,
        ST_FLASH      = 3'd6,
        ST_STOP       = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FLASH  = 2'b01,
        MODE_STOP   = 2'b10
    } mode_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    // Selector 11 behaves as all-red stop.
    function automatic mode_t mode_decode(input logic [1:0] sel);
        mode_t m;
        case (sel)
            2'b00:   m = MODE_NORMAL;
            2'b01:   m = MODE_FLASH;
            default: m = MODE_STOP;
        endcase
        return m;
    endfunction

    // Entry lamp word for road A; FLASH starts lit.
    function automatic logic [2:0] lamp_a(input state_t s);
        logic [2:0] l;
        case (s)
            ST_A_GREEN:  l = GRN;
            ST_A_YELLOW: l = YEL;
            ST_FLASH:    l = YEL;
            default:     l = RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] lamp_b(input state_t s);
        logic [2:0] l;
        case (s)
            ST_B_GREEN:  l = GRN;
            ST_B_YELLOW: l = YEL;
            ST_FLASH:    l = YEL;
            default:     l = RED;
        endcase
        return l;
    endfunction

    function automatic logic is_all_red(input state_t s);
        return (s == ST_ALL_RED_BA) || (s == ST_ALL_RED_AB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/semafor_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : semafor_scheduler_if
// Description : Request/mode inputs and lamp outputs of the semafor scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface semafor_scheduler_if;
    logic [1:0] Sel_in;
    logic       req_a;
    logic       req_b;
    logic       ped_req;
    logic [2:0] RGB_A;
    logic [2:0] RGB_B;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output Sel_in, req_a, req_b, ped_req,
        input  RGB_A, RGB_B, ped_walk, phase
    );

    modport slave (
        input  Sel_in, req_a, req_b, ped_req,
        output RGB_A, RGB_B, ped_walk, phase
    );
endinterface
`default_nettype wire

// File: rtl/semafor_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : semafor_tick_timer
// Description : Prescaler producing a tick every CLK_DIV cycles and a
//               saturating count of completed ticks; restart clears both.
// Revision    : 1.0 - initial release
// ============================================================================
module semafor_tick_timer #(
    parameter int CLK_DIV = 50,
    parameter int TW      = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          restart,
    output logic               tick,
    output logic [TW-1:0]      elapsed
);

    localparam int              c_PW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(CLK_DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [TW-1:0]   r_elapsed;

    assign tick    = (r_presc == c_LAST);
    assign elapsed = r_elapsed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (restart) begin
            r_presc   <= '0;
            r_elapsed <= '0;
        end else if (tick) begin
            r_presc <= '0;
            if (r_elapsed != {TW{1'b1}}) begin
                r_elapsed <= r_elapsed + 1'b1;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/semafor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : semafor_scheduler
// Description : Demand-driven two-road phase controller with min/max green,
//               yellow, all-red clearance, pedestrian walk and mode override.
// Revision    : 1.0 - initial release
// ============================================================================
module semafor_scheduler
    import semafor_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 1,
    parameter int PED_T     = 4,
    parameter int TW        = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    semafor_scheduler_if.slave  bus
);

    localparam logic [TW:0] c_MIN_G   = (TW+1)'(MIN_GREEN);
    localparam logic [TW:0] c_MAX_G   = (TW+1)'(MAX_GREEN);
    localparam logic [TW:0] c_YEL_T   = (TW+1)'(YELLOW_T);
    localparam logic [TW:0] c_CLEAR_T = (TW+1)'(ALL_RED_T);
    localparam logic [TW:0] c_PED_T   = (TW+1)'(PED_T);

    state_t      r_state;
    logic [2:0]  r_rgb_a;
    logic [2:0]  r_rgb_b;
    logic        r_ped_walk;
    logic        r_lit;
    logic        r_pend_a;
    logic        r_pend_b;
    logic        r_pend_p;

    logic          w_tick;
    logic [TW-1:0] w_elapsed;
    logic [TW:0]   w_count;
    logic          w_exit;
    state_t        w_next;
    mode_t         w_mode;

    semafor_tick_timer #(
        .CLK_DIV (CLK_DIV),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (w_exit),
        .tick    (w_tick),
        .elapsed (w_elapsed)
    );

    // Ticks completed including the current one, so a duration of N ticks
    // ends on the tick where w_count reaches N.
    assign w_count = {1'b0, w_elapsed} + (TW+1)'(1);
    assign w_mode  = mode_decode(bus.Sel_in);

    always_comb begin
        w_exit = 1'b0;
        w_next = r_state;
        case (r_state)
            ST_ALL_RED_BA, ST_ALL_RED_AB: begin
                w_exit = w_tick && (w_count >= (r_ped_walk ? c_PED_T : c_CLEAR_T));
                if (w_mode == MODE_FLASH)     w_next = ST_FLASH;
                else if (w_mode == MODE_STOP) w_next = ST_STOP;
                else if (r_state == ST_ALL_RED_AB) w_next = ST_B_GREEN;
                else                          w_next = ST_A_GREEN;
            end
            ST_A_GREEN: begin
                w_exit = w_tick && (w_count >= c_MIN_G)
                         && ((w_mode != MODE_NORMAL) || r_pend_b || r_pend_p)
                         && !(r_pend_a && (w_mode == MODE_NORMAL) && (w_count < c_MAX_G));
                w_next = ST_A_YELLOW;
            end
            ST_B_GREEN: begin
                w_exit = w_tick && (w_count >= c_MIN_G)
                         && ((w_mode != MODE_NORMAL) || r_pend_a || r_pend_p)
                         && !(r_pend_b && (w_mode == MODE_NORMAL) && (w_count < c_MAX_G));
                w_next = ST_B_YELLOW;
            end
            ST_A_YELLOW: begin
                w_exit = w_tick && (w_count >= c_YEL_T);
                w_next = ST_ALL_RED_AB;
            end
            ST_B_YELLOW: begin
                w_exit = w_tick && (w_count >= c_YEL_T);
                w_next = ST_ALL_RED_BA;
            end
            ST_FLASH: begin
                w_exit = w_tick && (w_mode != MODE_FLASH);
                w_next = (w_mode == MODE_NORMAL) ? ST_ALL_RED_BA : ST_STOP;
            end
            ST_STOP: begin
                w_exit = w_tick && (w_mode != MODE_STOP);
                w_next = (w_mode == MODE_NORMAL) ? ST_ALL_RED_BA : ST_FLASH;
            end
            default: begin
                w_exit = 1'b1;
                w_next = ST_ALL_RED_BA;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ALL_RED_BA;
            r_rgb_a    <= RED;
            r_rgb_b    <= RED;
            r_ped_walk <= 1'b0;
            r_lit      <= 1'b1;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_pend_p   <= 1'b0;
        end else begin
            // A request arriving in the same cycle as the clear is kept.
            if (bus.req_a)                              r_pend_a <= 1'b1;
            else if (w_exit && (w_next == ST_A_GREEN))  r_pend_a <= 1'b0;
            if (bus.req_b)                              r_pend_b <= 1'b1;
            else if (w_exit && (w_next == ST_B_GREEN))  r_pend_b <= 1'b0;
            if (bus.ped_req)                            r_pend_p <= 1'b1;
            else if (w_exit && r_ped_walk)              r_pend_p <= 1'b0;

            if (w_exit) begin
                r_state    <= w_next;
                r_rgb_a    <= lamp_a(w_next);
                r_rgb_b    <= lamp_b(w_next);
                r_lit      <= 1'b1;
                r_ped_walk <= is_all_red(w_next) && (r_pend_p || bus.ped_req);
            end else if ((r_state == ST_FLASH) && w_tick) begin
                r_lit   <= ~r_lit;
                r_rgb_a <= r_lit ? OFF : YEL;
                r_rgb_b <= r_lit ? OFF : YEL;
            end
        end
    end

    assign bus.RGB_A    = r_rgb_a;
    assign bus.RGB_B    = r_rgb_b;
    assign bus.ped_walk = r_ped_walk;
    assign bus.phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_semafor_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_semafor_scheduler
// Description : Directed self-checking bench for semafor_scheduler at CLK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semafor_scheduler;

    localparam logic [2:0] P_ARBA  = 3'd0;
    localparam logic [2:0] P_AG    = 3'd1;
    localparam logic [2:0] P_AY    = 3'd2;
    localparam logic [2:0] P_ARAB  = 3'd3;
    localparam logic [2:0] P_BG    = 3'd4;
    localparam logic [2:0] P_BY    = 3'd5;
    localparam logic [2:0] P_FLASH = 3'd6;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc;

    semafor_scheduler_if bus ();

    semafor_scheduler #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_lamps(input string tag, input logic [2:0] ph,
                             input logic [2:0] a, input logic [2:0] b);
        chk({tag, "_phase"}, {29'd0, bus.phase}, {29'd0, ph});
        chk({tag, "_rgb_a"}, {29'd0, bus.RGB_A}, {29'd0, a});
        chk({tag, "_rgb_b"}, {29'd0, bus.RGB_B}, {29'd0, b});
    endtask

    task automatic wait_phase(input logic [2:0] target, input int budget, output int cycles);
        cycles = 0;
        while (bus.phase !== target && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.Sel_in  = 2'b00;
        bus.req_a   = 1'b0;
        bus.req_b   = 1'b0;
        bus.ped_req = 1'b0;
        step(2);
        chk_lamps("rst", P_ARBA, 3'b100, 3'b100);
        chk("rst_walk", {31'd0, bus.ped_walk}, 32'd0);
        reset = 1'b0;

        // Reset release: 4-cycle clearance, then A green.
        step(3);
        chk_lamps("s1_arba", P_ARBA, 3'b100, 3'b100);
        step(1);
        chk_lamps("s1_ag", P_AG, 3'b001, 3'b100);

        // One-cycle B request five cycles into A green.
        step(4);
        bus.req_b = 1'b1;
        step(1);
        bus.req_b = 1'b0;
        step(14);
        chk_lamps("s2_ag_min", P_AG, 3'b001, 3'b100);
        step(1);
        chk_lamps("s2_ay", P_AY, 3'b010, 3'b100);
        step(11);
        chk("s2_ay_end", {29'd0, bus.phase}, {29'd0, P_AY});
        step(1);
        chk_lamps("s2_arab", P_ARAB, 3'b100, 3'b100);
        step(3);
        chk("s2_arab_end", {29'd0, bus.phase}, {29'd0, P_ARAB});
        step(1);
        chk_lamps("s2_bg", P_BG, 3'b100, 3'b001);

        // Pedestrian plus A request during B green: walk served in 16-cycle all-red.
        bus.req_a   = 1'b1;
        bus.ped_req = 1'b1;
        step(1);
        bus.req_a   = 1'b0;
        bus.ped_req = 1'b0;
        step(18);
        chk("s4_bg_min", {29'd0, bus.phase}, {29'd0, P_BG});
        step(1);
        chk_lamps("s4_by", P_BY, 3'b100, 3'b010);
        step(11);
        chk("s4_by_end", {29'd0, bus.phase}, {29'd0, P_BY});
        step(1);
        chk_lamps("s4_arba", P_ARBA, 3'b100, 3'b100);
        chk("s4_walk_on", {31'd0, bus.ped_walk}, 32'd1);
        step(15);
        chk("s4_arba_end", {29'd0, bus.phase}, {29'd0, P_ARBA});
        chk("s4_walk_end", {31'd0, bus.ped_walk}, 32'd1);
        step(1);
        chk_lamps("s4_ag", P_AG, 3'b001, 3'b100);
        chk("s4_walk_off", {31'd0, bus.ped_walk}, 32'd0);

        // B pending while A keeps requesting: green stretches to MAX_GREEN.
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        step(1);
        bus.req_b = 1'b0;
        step(18);
        chk("s3_ag_past_min", {29'd0, bus.phase}, {29'd0, P_AG});
        step(60);
        chk("s3_ag_before_max", {29'd0, bus.phase}, {29'd0, P_AG});
        step(1);
        chk_lamps("s3_ay_at_max", P_AY, 3'b010, 3'b100);
        bus.req_a = 1'b0;
        // Yellow 12 + clear 4 + B green 20 + yellow 12 + clear 4.
        wait_phase(P_AG, 100, cyc);
        chk("s3_return_cycles", cyc, 32'd52);

        // Flash mode requested during A green.
        bus.Sel_in = 2'b01;
        step(19);
        chk("s5_ag_min", {29'd0, bus.phase}, {29'd0, P_AG});
        step(1);
        chk_lamps("s5_ay", P_AY, 3'b010, 3'b100);
        step(12);
        chk_lamps("s5_arab", P_ARAB, 3'b100, 3'b100);
        step(4);
        chk_lamps("s5_flash_lit", P_FLASH, 3'b010, 3'b010);
        step(3);
        chk_lamps("s5_flash_lit_end", P_FLASH, 3'b010, 3'b010);
        step(1);
        chk_lamps("s5_flash_dark", P_FLASH, 3'b000, 3'b000);
        step(4);
        chk_lamps("s5_flash_relit", P_FLASH, 3'b010, 3'b010);
        bus.Sel_in = 2'b00;
        step(3);
        chk("s5_flash_hold", {29'd0, bus.phase}, {29'd0, P_FLASH});
        step(1);
        chk_lamps("s5_arba", P_ARBA, 3'b100, 3'b100);
        step(4);
        chk_lamps("s5_ag", P_AG, 3'b001, 3'b100);

        // Asynchronous reset in the middle of A yellow.
        bus.req_b = 1'b1;
        step(1);
        bus.req_b = 1'b0;
        step(19);
        chk("s6_ay", {29'd0, bus.phase}, {29'd0, P_AY});
        step(5);
        #2;
        reset = 1'b1;
        #1;
        chk_lamps("s6_async", P_ARBA, 3'b100, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        step(3);
        chk("s6_arba", {29'd0, bus.phase}, {29'd0, P_ARBA});
        step(1);
        chk_lamps("s6_ag", P_AG, 3'b001, 3'b100);
        step(200);
        chk_lamps("s6_ag_hold", P_AG, 3'b001, 3'b100);
        chk("s6_walk", {31'd0, bus.ped_walk}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/semafor_scheduler.md
Name: semafor_scheduler

Overview:
- Demand-driven phase controller for a two-road intersection; drives RGB_A/RGB_B lamp words directly.
- Replaces the fixed-cycle semafor sequencing with sensor requests (req_a, req_b) and a pedestrian button (ped_req).
- Enforces min/max green, yellow and all-red clearance.
- Accepts a mode selector for normal, flashing-yellow or all-red operation, and switches modes only at safe points.

Parameters:
- CLK_DIV, 50, clk cycles per tick (time base); must be ≥2.
- MIN_GREEN, 5, minimum green duration in ticks.
- MAX_GREEN, 20, green duration in ticks after which a pending opposite request forces a switch.
- YELLOW_T, 3, yellow duration in ticks.
- ALL_RED_T, 1, all-red clearance in ticks.
- PED_T, 4, all-red duration in ticks when a pedestrian walk is served.
- TW, 8, tick-timer width; must hold max(MAX_GREEN, PED_T).

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: reset, asynchronous, active-high.
- Sel_in, in, 2: mode. 00 = normal, 01 = flash yellow, 10 = all red, 11 = treated as 10.
- req_a, in, 1: vehicle waiting on road A (level, synchronous to clk).
- req_b, in, 1: vehicle waiting on road B.
- ped_req, in, 1: pedestrian button (level, ≥1 cycle).
- RGB_A, out, 3: lamp word for road A. Bit2 = red, bit1 = yellow, bit0 = green.
- RGB_B, out, 3: lamp word for road B.
- ped_walk, out, 1: walk lamp.
- phase, out, 3: current state encoding, for debug and bench use.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Time base:
  - Prescaler counts 0..CLK_DIV-1; tick=1 on the cycle where the prescaler equals CLK_DIV-1.
  - Prescaler and tick timer both clear on every state entry, so a duration of N ticks is exactly N*CLK_DIV cycles.
  - Tick timer saturates at 2^TW-1.
- States:
  - ALL_RED_BA, A_GREEN, A_YELLOW, ALL_RED_AB, B_GREEN, B_YELLOW, FLASH, STOP.
  - Outputs are registered Moore outputs of the state.
- Lamp words per state:
  - A_GREEN: A=001, B=100.
  - A_YELLOW: A=010, B=100.
  - B_GREEN: A=100, B=001.
  - B_YELLOW: A=100, B=010.
  - ALL_RED_*: 100/100.
  - STOP: 100/100.
  - FLASH: both 010 for one tick, then both 000 for one tick, repeating; starts lit on entry.
- Reset:
  - State = ALL_RED_BA; RGB_A = RGB_B = 100; ped_walk = 0.
  - Pending flags cleared; timers cleared.
  - Reset mid-phase abandons the phase immediately; no yellow.
- Pending flags:
  - pend_a, pend_b and pend_p set on any cycle their input is 1.
  - pend_a clears on entry to A_GREEN; pend_b clears on entry to B_GREEN.
  - pend_p clears on the exit of an ALL_RED state that served the walk.
  - A set and a clear in the same cycle: set wins.
- A_GREEN exit: on a tick where elapsed ≥ MIN_GREEN, mode ≠ 00, or pend_b, or pend_p, go to A_YELLOW, subject to:
  - if pend_a was re-asserted during green and mode = 00, switch only once elapsed ≥ MAX_GREEN;
  - with no opposite demand, green holds indefinitely.
  - B_GREEN is symmetric.
- Yellow exit: A_YELLOW → ALL_RED_AB after YELLOW_T ticks; B_YELLOW → ALL_RED_BA after YELLOW_T ticks.
- All-red:
  - Duration is PED_T with ped_walk=1 if pend_p was set at entry; otherwise ALL_RED_T.
  - Then: mode 01 → FLASH; mode 1x → STOP; otherwise ALL_RED_AB → B_GREEN and ALL_RED_BA → A_GREEN.
- FLASH/STOP: when mode returns to 00, go to ALL_RED_BA on the next tick; FLASH ↔ STOP transitions take effect on the next tick.
- Mode change during yellow or all-red completes the current phase first; red never skips clearance.
- Invariant: both roads are never simultaneously non-red except in FLASH.

Decomposition:
- semafor_pkg holds:
  - state enum/localparams;
  - lamp constants RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000;
  - mode codes.
- Sub-module semafor_tick_timer:
  - contains the prescaler and saturating tick counter;
  - inputs clk, reset, restart;
  - outputs tick, elapsed[TW-1:0].

Test Plan (CLK_DIV=4, defaults otherwise):
1. Reset release, no requests.
   - ALL_RED_BA lasts 4 cycles, then A_GREEN (RGB_A=001, RGB_B=100).
   - Holds A_GREEN for ≥200 cycles.
2. req_b pulsed 1 cycle at cycle 5 after A_GREEN entry.
   - A_GREEN persists until 20 cycles (MIN_GREEN).
   - Then A_YELLOW for 12 cycles, ALL_RED_AB for 4 cycles, then B_GREEN; pend_b cleared.
3. req_b pending, req_a held high throughout A_GREEN.
   - Switch to A_YELLOW exactly at 80 cycles (MAX_GREEN).
4. ped_req pulsed during B_GREEN with pend_a set.
   - ALL_RED_BA lasts 16 cycles with ped_walk=1, then A_GREEN with ped_walk=0.
5. Sel_in=01 during A_GREEN.
   - A_YELLOW → ALL_RED_AB → FLASH; lamps alternate 010/000 every 4 cycles.
   - Sel_in=00 → ALL_RED_BA → A_GREEN.
6. reset asserted mid A_YELLOW.
   - Outputs become 100/100 asynchronously, before the next clk edge.
   - After release, the sequence of scenario 1 repeats.
